// File: rtl/vic_vect_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vic_vect_arbiter_pkg
//   Shared constants and types for the vectored-IRQ arbiter slice.
//   No ports; imported by the arbiter top level.
// ---------------------------------------------------------------------------
package vic_vect_arbiter_pkg;

  localparam int VIC_INTW        = 32;  // number of interrupt sources
  localparam int VIC_NSLOT       = 16;  // number of vectored slots, slot 0 = highest priority
  localparam int VIC_SRCW        = 5;   // source-select field width, log2(VIC_INTW)
  localparam int ADDR_BW         = 32;  // vector address width
  localparam int VIC_LVL_W       = 5;   // width of a level number 0..VIC_NSLOT+1

  // Level number: 0..NSLOT-1 vectored slots, NSLOT default, NSLOT+1 idle.
  typedef logic [VIC_LVL_W-1:0] vic_lvl_t;

endpackage : vic_vect_arbiter_pkg

// File: rtl/vic_prio_enc.sv
// ---------------------------------------------------------------------------
// vic_prio_enc
//   Lowest-set-bit priority encoder.
//   Ports:
//     vec   in  W   request vector, bit 0 = highest priority
//     idx   out IW  index of the lowest set bit (0 when none set)
//     valid out 1   at least one bit of vec is set
// ---------------------------------------------------------------------------
module vic_prio_enc #(
  parameter int W  = 16,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      idx   = vec[i] ? IW'(i) : idx;
      valid = valid | vec[i];
    end
  end

endmodule : vic_prio_enc

// File: rtl/vic_vect_arbiter.sv
// ---------------------------------------------------------------------------
// vic_vect_arbiter
//   Vectored-IRQ priority arbiter and nesting controller behind the VIC
//   register file. Selects the highest-priority pending vectored slot (or the
//   default vector), presents its address, and tracks in-service levels
//   across VICVectAddr reads (acknowledge) and writes (end of interrupt).
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     irq_status      masked IRQ status (INTW)
//     slot_en         per-slot enable (NSLOT)
//     slot_src        per-slot source number, slot n at [n*SRC_W +: SRC_W]
//     slot_addr       per-slot vector address, slot n at [n*ADDR_BW +: ADDR_BW]
//     def_addr        default vector address
//     vect_rd         1-cycle strobe, VICVectAddr read (acknowledge)
//     vect_wr         1-cycle strobe, VICVectAddr write (end of interrupt)
//     vect_addr_out   registered vector address
//     irq_req         registered interrupt request
//     cur_slot        registered winning level, NSLOT = default
//     in_service      registered in-service mask, bit NSLOT = default level
// ---------------------------------------------------------------------------
module vic_vect_arbiter
  import vic_vect_arbiter_pkg::*;
#(
  parameter int INTW     = VIC_INTW,
  parameter int NSLOT    = VIC_NSLOT,
  parameter int SRC_W    = VIC_SRCW,
  parameter int ADDR_BW_P = ADDR_BW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INTW-1:0]            irq_status,
  input  logic [NSLOT-1:0]           slot_en,
  input  logic [NSLOT*SRC_W-1:0]     slot_src,
  input  logic [NSLOT*ADDR_BW_P-1:0] slot_addr,
  input  logic [ADDR_BW_P-1:0]       def_addr,
  input  logic                       vect_rd,
  input  logic                       vect_wr,
  output logic [ADDR_BW_P-1:0]       vect_addr_out,
  output logic                       irq_req,
  output logic [VIC_LVL_W-1:0]       cur_slot,
  output logic [NSLOT:0]             in_service
);

  localparam int WIN_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  // Clear the lowest set bit of an in-service mask (no-op on zero).
  function automatic logic [NSLOT:0] clr_lowest(input logic [NSLOT:0] m);
    return m & (m - {{NSLOT{1'b0}}, 1'b1});
  endfunction

  // One-hot in-service bit for a level number.
  function automatic logic [NSLOT:0] lvl_onehot(input vic_lvl_t lvl);
    return {{NSLOT{1'b0}}, 1'b1} << lvl;
  endfunction

  logic [ADDR_BW_P-1:0] vect_addr_d, vect_addr_q;
  logic                 irq_req_d,   irq_req_q;
  vic_lvl_t             cur_slot_d,  cur_slot_q;
  logic [NSLOT:0]       in_service_d, in_service_q;

  logic [NSLOT-1:0]     hit;
  logic [INTW-1:0]      claimed;
  logic                 def_hit;
  logic [SRC_W-1:0]     src_v;
  logic [NSLOT-1:0]     below_lvl;
  vic_lvl_t             level;
  vic_lvl_t             lvl_idx;
  logic                 lvl_valid;
  logic [WIN_W-1:0]     win_idx;
  logic                 win_valid;

  // Per-slot hits, claimed-source map, default hit and next in-service mask.
  // The EOI clear always works on the pre-cycle mask before the ack sets
  // its bit, which gives the required rd+wr same-cycle behaviour.
  always_comb begin
    hit     = '0;
    claimed = '0;
    src_v   = '0;
    for (int n = 0; n < NSLOT; n++) begin
      src_v = slot_src[n*SRC_W +: SRC_W];
      if (slot_en[n] && (int'(src_v) < INTW)) begin
        hit[n]         = irq_status[src_v];
        claimed[src_v] = 1'b1;
      end else begin
        hit[n] = 1'b0;
      end
    end
    def_hit = |(irq_status & ~claimed);

    in_service_d = vect_wr ? clr_lowest(in_service_q) : in_service_q;
    if (vect_rd && irq_req_q) begin
      in_service_d = in_service_d | lvl_onehot(cur_slot_q);
    end else begin
      in_service_d = in_service_d;
    end
  end

  // Current level is taken from the next in-service mask so that the
  // request drops on the same edge that records the acknowledge, and an
  // EOI re-opens lower levels on the same edge that retires the level.
  vic_prio_enc #(.W(NSLOT + 1), .IW(VIC_LVL_W)) u_lvl_enc (
    .vec   (in_service_d),
    .idx   (lvl_idx),
    .valid (lvl_valid)
  );

  // Slots strictly above the current level (lower index) may still nest.
  always_comb begin
    level     = lvl_valid ? lvl_idx : vic_lvl_t'(NSLOT + 1);
    below_lvl = '0;
    for (int n = 0; n < NSLOT; n++) begin
      below_lvl[n] = (n < int'(level));
    end
  end

  vic_prio_enc #(.W(NSLOT), .IW(WIN_W)) u_win_enc (
    .vec   (hit & below_lvl),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // Output next-state: vectored winner, else default (only when nothing
  // is in service at all), else idle.
  always_comb begin
    irq_req_d   = 1'b0;
    cur_slot_d  = vic_lvl_t'(NSLOT);
    vect_addr_d = def_addr;
    if (win_valid) begin
      irq_req_d   = 1'b1;
      cur_slot_d  = vic_lvl_t'(win_idx);
      vect_addr_d = slot_addr[int'(win_idx)*ADDR_BW_P +: ADDR_BW_P];
    end else if (def_hit && !lvl_valid) begin
      irq_req_d = 1'b1;
    end else begin
      irq_req_d = 1'b0;
    end
  end

  // State and output registers; reset discards any nesting in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vect_addr_q  <= '0;
      irq_req_q    <= 1'b0;
      cur_slot_q   <= vic_lvl_t'(NSLOT);
      in_service_q <= '0;
    end else begin
      vect_addr_q  <= vect_addr_d;
      irq_req_q    <= irq_req_d;
      cur_slot_q   <= cur_slot_d;
      in_service_q <= in_service_d;
    end
  end

  assign vect_addr_out = vect_addr_q;
  assign irq_req       = irq_req_q;
  assign cur_slot      = cur_slot_q;
  assign in_service    = in_service_q;

endmodule : vic_vect_arbiter
